regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the pipelined processor datapath, generalising the 2-read/1-write register file. Provides NUM_RD combinational read ports, NUM_WR write ports with fixed priority, same-cycle write-to-read bypass, optional hardwired-zero register 0, and a per-register pending scoreboard for decode-stage hazard detection. Sits between decode (reads, issue) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2); higher index has priority
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, never pending

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- readreg  in  NUM_RD*ADDR_W  read addresses, port r at bits [r*ADDR_W +: ADDR_W]
- readdata  out  NUM_RD*DATA_W  read data, port r at bits [r*DATA_W +: DATA_W]
- rd_pending  out  NUM_RD  1 = addressed register awaits an outstanding write
- writereg  in  NUM_WR*ADDR_W  write addresses
- writedata  in  NUM_WR*DATA_W  write data
- RegWrite  in  NUM_WR  per-port write enable
- issue_valid  in  1  marks issue_reg as having an outstanding producer
- issue_reg  in  ADDR_W  destination register being issued

## Operation
- Storage: 2**ADDR_W x DATA_W flip-flop array plus 2**ADDR_W pending bits.
- Write: at rising clk, for each w with RegWrite[w]=1, mem[writereg[w]] <= writedata[w]. Same address on both ports: port 1 wins. Address 0 ignored when ZERO_REG=1.
- Read (combinational), per port r, priority order:
  - rst=1 -> 0
  - ZERO_REG=1 and readreg[r]=0 -> 0
  - highest-index w with RegWrite[w]=1 and writereg[w]=readreg[r] -> writedata[w] (bypass)
  - otherwise mem[readreg[r]]
- Scoreboard, at rising clk:
  - clear pending[a] for every a written this cycle
  - then set pending[issue_reg] if issue_valid=1 (set wins over clear on same address)
  - issue_reg=0 ignored when ZERO_REG=1
- rd_pending[r] = pending[readreg[r]] AND NOT (bypass hit on port r this cycle); forced 0 when rst=1 or (ZERO_REG=1 and readreg[r]=0).
- Reset (rst=1 at rising clk): all mem entries and all pending bits cleared; writes and issue that cycle discarded.

## Timing
- Read latency 0 cycles (combinational from readreg, write inputs, and state).
- Write visible via bypass in the same cycle, via array from the next cycle.
- Pending set by issue at edge N is visible on rd_pending after edge N; cleared by write at edge M, but masked in cycle M-1 via bypass.
- Reset values: readdata = 0, rd_pending = 0 on every port during and after reset until a write occurs.
- Reset asserted mid-operation: state cleared at that edge regardless of concurrent RegWrite/issue_valid; no partial updates.
- No back-pressure; every write and issue is accepted in the cycle it is presented.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W constants and a function returning the bypass-select index for one read port.
- One sub-module: rf_read_port (per-port priority mux implementing bypass, zero-register and reset forcing, plus rd_pending masking); instantiated NUM_RD times via generate.
- Array, write logic and scoreboard stay in regfile_mp.

## Test plan
- Reset then read all 32 addresses on both ports -> readdata=0, rd_pending=0 everywhere.
- Write 123 to r15, read r15 same cycle -> readdata=123 (bypass); next cycle with RegWrite=0 -> still 123 from array.
- Write 0xDEADBEEF to r0 (ZERO_REG=1) -> reads of r0 return 0 the same and following cycles; issue_reg=0 never sets rd_pending.
- NUM_WR=2: port0 writes 5, port1 writes 9, both to r7 -> same-cycle read returns 9, next cycle mem[7]=9.
- issue_valid with issue_reg=16 -> rd_pending=1 for r16 next cycle; in the writeback cycle (RegWrite, writereg=16, data 77) rd_pending=0 and readdata=77; simultaneous issue and write to r16 -> pending remains 1 afterward.
- Write 55 to r3, then assert rst together with RegWrite to r3 (data 66) -> after that edge r3 reads 0, no pending bits set.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and bypass-select helper for regfile_mp
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Widest write-port count supported; hit vectors are padded to this width.
  localparam int MAX_WR = 2;
  localparam int WSEL_W = 1;

  // Highest-index set bit of the write-hit vector wins the bypass.
  // Returns 0 when no bit is set; callers qualify with a separate any-hit flag.
  function automatic logic [WSEL_W-1:0] bypass_sel(input logic [MAX_WR-1:0] hit);
    logic [WSEL_W-1:0] sel;
    sel = '0;
    for (int w = 0; w < MAX_WR; w++) begin
      if (hit[w]) sel = WSEL_W'(w);
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one read port: reset/zero forcing, write bypass, pending mask
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  input  logic                     pend_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     rpend_o
);

  logic [MAX_WR-1:0] hit;
  logic [WSEL_W-1:0] sel;
  logic [DATA_W-1:0] byp_data;
  logic              any_hit;
  logic              force_zero;

  // Detect which write ports target this read address this cycle.
  always_comb begin
    hit = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      hit[w] = wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == raddr_i);
    end
  end

  assign any_hit    = |hit;
  assign sel        = bypass_sel(hit);
  assign force_zero = rst_i || (ZERO_REG && (raddr_i == '0));

  // Pick the data of the highest-priority hitting write port.
  always_comb begin
    byp_data = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (WSEL_W'(w) == sel) byp_data = wr_data_i[w*DATA_W +: DATA_W];
    end
  end

  // Final read priority: forced zero, then bypass, then the stored value.
  always_comb begin
    rdata_o = mem_data_i;
    rpend_o = pend_i;
    if (force_zero) begin
      rdata_o = '0;
      rpend_o = 1'b0;
    end else if (any_hit) begin
      rdata_o = byp_data;
      rpend_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass and pending scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] readreg,
  output logic [NUM_RD*DATA_W-1:0] readdata,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR*ADDR_W-1:0] writereg,
  input  logic [NUM_WR*DATA_W-1:0] writedata,
  input  logic [NUM_WR-1:0]        RegWrite,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  // Next pending vector: clear written registers, then set the issued one.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (RegWrite[w]) pend_d[writereg[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (issue_valid && !(ZERO_REG && (issue_reg == '0))) begin
      pend_d[issue_reg] = 1'b1;
    end
  end

  // Register array writes; ascending port order lets the higher index win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (RegWrite[w] && !(ZERO_REG && (writereg[w*ADDR_W +: ADDR_W] == '0))) begin
          mem_q[writereg[w*ADDR_W +: ADDR_W]] <= writedata[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Pending scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    assign raddr = readreg[r*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rst_i     (rst),
      .raddr_i   (raddr),
      .mem_data_i(mem_q[raddr]),
      .pend_i    (pend_q[raddr]),
      .wr_addr_i (writereg),
      .wr_data_i (writedata),
      .wr_en_i   (RegWrite),
      .rdata_o   (readdata[r*DATA_W +: DATA_W]),
      .rpend_o   (rd_pending[r])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard testbench for regfile_mp
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] readreg;
  logic [NUM_RD*DATA_W-1:0] readdata;
  logic [NUM_RD-1:0]        rd_pending;
  logic [NUM_WR*ADDR_W-1:0] writereg;
  logic [NUM_WR*DATA_W-1:0] writedata;
  logic [NUM_WR-1:0]        RegWrite;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_reg;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        pend;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .readreg    (readreg),
    .readdata   (readdata),
    .rd_pending (rd_pending),
    .writereg   (writereg),
    .writedata  (writedata),
    .RegWrite   (RegWrite),
    .issue_valid(issue_valid),
    .issue_reg  (issue_reg)
  );

  // Monitor: outputs are settled mid-cycle; drain every expectation queued this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] got_d;
      logic        got_p;
      e = exp_q.pop_front();
      got_d = readdata[e.port*DATA_W +: DATA_W];
      got_p = rd_pending[e.port];
      checks++;
      if (got_d !== e.data || got_p !== e.pend) begin
        errors++;
        $display("FAIL %s port%0d: got data=%h pend=%b, expected data=%h pend=%b",
                 e.name, e.port, got_d, got_p, e.data, e.pend);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    RegWrite    = '0;
    issue_valid = 1'b0;
  endtask

  task automatic rd(input int p, input logic [ADDR_W-1:0] a);
    readreg[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input int p, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    RegWrite[p]                   = 1'b1;
    writereg[p*ADDR_W +: ADDR_W]  = a;
    writedata[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a);
    issue_valid = 1'b1;
    issue_reg   = a;
  endtask

  task automatic expect_rd(input int p, input logic [31:0] d, input logic pnd, input string n);
    exp_t e;
    e.port = p; e.data = d; e.pend = pnd; e.name = n;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; readreg = '0; writereg = '0; writedata = '0;
    RegWrite = '0; issue_valid = 1'b0; issue_reg = '0;

    // During reset: reads forced to 0 even with a write/issue to the same register.
    @(posedge clk); #1;
    rst = 1'b1;
    rd(0, 5); rd(1, 9); wr(0, 5, 32'h1111_2222); issue(9);
    expect_rd(0, 0, 0, "reset_bypass_forced");
    expect_rd(1, 0, 0, "reset_pend_forced");

    // Every address reads 0 and not pending after reset.
    for (int a = 0; a < 32; a++) begin
      step();
      rd(0, 5'(a)); rd(1, 5'(31 - a));
      expect_rd(0, 0, 0, "post_reset_all");
      expect_rd(1, 0, 0, "post_reset_all");
    end

    // Bypass then array read of r15.
    step(); wr(0, 15, 123); rd(0, 15);
    expect_rd(0, 123, 0, "r15_bypass");
    step(); rd(0, 15);
    expect_rd(0, 123, 0, "r15_array");

    // Hardwired zero register: writes and issue ignored.
    step(); wr(0, 0, 32'hDEAD_BEEF); issue(0); rd(0, 0); rd(1, 0);
    expect_rd(0, 0, 0, "r0_write_same");
    expect_rd(1, 0, 0, "r0_write_same_p1");
    step(); rd(0, 0);
    expect_rd(0, 0, 0, "r0_after_write");

    // Dual write to r7: port 1 wins both in bypass and array.
    step(); wr(0, 7, 5); wr(1, 7, 9); rd(0, 7); rd(1, 6);
    expect_rd(0, 9, 0, "r7_dual_bypass");
    expect_rd(1, 0, 0, "r6_untouched");
    step(); rd(0, 7); rd(1, 15);
    expect_rd(0, 9, 0, "r7_dual_array");
    expect_rd(1, 123, 0, "r15_still");

    // Scoreboard on r16.
    step(); issue(16); rd(0, 16);
    expect_rd(0, 0, 0, "r16_issue_cycle");
    step(); rd(0, 16); rd(1, 16);
    expect_rd(0, 0, 1, "r16_pending");
    expect_rd(1, 0, 1, "r16_pending_p1");
    step(); wr(0, 16, 77); rd(0, 16);
    expect_rd(0, 77, 0, "r16_wb_masked");
    step(); rd(0, 16);
    expect_rd(0, 77, 0, "r16_cleared");
    step(); issue(16); wr(1, 16, 88); rd(0, 16);
    expect_rd(0, 88, 0, "r16_issue_and_write");
    step(); rd(0, 16);
    expect_rd(0, 88, 1, "r16_set_wins");

    // Mid-operation reset discards the concurrent write and issue.
    step(); wr(0, 3, 55); rd(0, 3);
    expect_rd(0, 55, 0, "r3_bypass");
    step(); rst = 1'b1; wr(0, 3, 66); issue(3); rd(0, 3); rd(1, 16);
    expect_rd(0, 0, 0, "r3_during_reset");
    expect_rd(1, 0, 0, "r16_during_reset");
    step(); rd(0, 3); rd(1, 16);
    expect_rd(0, 0, 0, "r3_after_reset");
    expect_rd(1, 0, 0, "r16_after_reset");
    step(); rd(0, 15); rd(1, 7);
    expect_rd(0, 0, 0, "r15_after_reset");
    expect_rd(1, 0, 0, "r7_after_reset");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected end before 200000");
    $fatal(1, "watchdog");
  end

endmodule
